// File: rtl/adder_pkg.sv
// adder_pkg: shared encodings and sizing helpers for the pipelined adder
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit split_ok(input int width, input int stages);
        return stages >= 1 && stages <= width && (width % stages) == 0;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple-carry adder built from full-adder cells
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);
    logic [CHUNK:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked ripple-carry add/subtract with valid/ready backpressure
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Index k feeds stage k; index k+1 is the register stage k writes.
    // Operands shift right by CHUNK per stage so each stage always adds the low chunk.
    logic [WIDTH-1:0] a_st [STAGES];
    logic [WIDTH-1:0] b_st [STAGES];
    logic [WIDTH-1:0] r_st [STAGES+1];
    logic [STAGES:0]  v_st;
    logic [STAGES:0]  c_st;
    logic             advance;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign a_st[0]   = a;
    assign b_st[0]   = (op == OP_SUB) ? ~b : b;
    assign c_st[0]   = (op == OP_SUB) ? 1'b1 : cin;
    assign v_st[0]   = in_valid;
    assign r_st[0]   = '0;
    assign out_valid = v_st[STAGES];
    assign sum       = r_st[STAGES];
    assign cout      = c_st[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] s;
        logic             co;
        logic             cm;
        logic [WIDTH-1:0] r_d;
        logic [WIDTH-1:0] r_q;
        logic             v_q;
        logic             c_q;

        rca_chunk #(.CHUNK(CHUNK)) u_rca (
            .a_i   (a_st[k][CHUNK-1:0]),
            .b_i   (b_st[k][CHUNK-1:0]),
            .cin_i (c_st[k]),
            .sum_o (s),
            .cout_o(co),
            .cmsb_o(cm)
        );

        // New chunk enters at the top; after the last stage chunk 0 sits at the bottom.
        assign r_d = (r_st[k] >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));

        // Stage result, carry and valid advance together or all hold on a stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (advance) begin
                v_q <= v_st[k];
                c_q <= co;
                r_q <= r_d;
            end
        end

        assign v_st[k+1] = v_q;
        assign c_st[k+1] = c_q;
        assign r_st[k+1] = r_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Carry the not-yet-consumed operand chunks to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_st[k] >> CHUNK;
                    b_q <= b_st[k] >> CHUNK;
                end
            end

            assign a_st[k+1] = a_q;
            assign b_st[k+1] = b_q;
        end else begin : g_last
            logic ovf_q;

            // Overflow needs the carry into bit WIDTH-1, only visible inside the last chunk.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= cm ^ co;
                end
            end

            assign ovf = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for the pipelined adder, plus a parameter sweep
module tb_pipelined_adder;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    res_t q[$];
    int   checks  = 0;
    int   passes  = 0;
    int   got     = 0;
    int   sw_done = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every taken output is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL spurious_output: got sum=%h with no result expected", sum);
            end else begin
                res_t e;
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("cout", cout, e.c);
                chk("ovf", ovf, e.o);
                got++;
            end
        end
    end

    // Hold the operation until the DUT accepts it, then record the expected result.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                        input logic tc, input res_t e);
        bit ok;
        ok = 0;
        a = ta; b = tb; op = top; cin = tc; in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL accept_timeout: in_ready never rose, required 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int         n;
        int         seen;
        logic [W-1:0] held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0});
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 4);
        @(posedge clk);
        #1;

        send(16'hFFFF, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
        send(16'h0005, 16'h0007, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b0});
        send(16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b1});
        send(16'hABCD, 16'hABCD, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0});
        drain();

        fork
            begin
                send(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0});
                send(16'h1000, 16'h2000, 1'b0, 1'b1, '{16'h3001, 1'b0, 1'b0});
                send(16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1});
                send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, '{16'hFFFF, 1'b1, 1'b0});
                send(16'h0100, 16'h0001, 1'b1, 1'b1, '{16'h00FF, 1'b1, 1'b0});
                send(16'h0000, 16'h0001, 1'b1, 1'b0, '{16'hFFFF, 1'b0, 1'b0});
                send(16'h00F0, 16'h000F, 1'b0, 1'b0, '{16'h00FF, 1'b0, 1'b0});
                send(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, '{16'h8000, 1'b0, 1'b1});
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                held = sum;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_hold_sum", sum, held);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
                @(negedge clk);
                chk("resume_in_ready", in_ready, 1);
            end
        join
        drain();
        chk("result_count", got, 14);

        send(16'h1111, 16'h1111, 1'b0, 1'b0, '{16'h2222, 1'b0, 1'b0});
        send(16'h2222, 16'h1111, 1'b0, 1'b0, '{16'h3333, 1'b0, 1'b0});
        send(16'h3333, 16'h1111, 1'b0, 1'b0, '{16'h4444, 1'b0, 1'b0});
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_sum", sum, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("post_reset_quiet", seen, 0);
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0002, 1'b0, 1'b0, '{16'h0003, 1'b0, 1'b0});
        drain();
        chk("final_count", got, 15);

        for (int i = 0; i < 3000 && sw_done < 4; i++) @(posedge clk);
        chk("sweep_done", sw_done, 4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Parameter sweep: one operation at a time against an arithmetic model.
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int SWD = (g == 3) ? 32 : 16;
        localparam int SST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 16 : 8;
        logic           r_n;
        logic           iv;
        logic           ir;
        logic           ov;
        logic           sop;
        logic           ci;
        logic           co;
        logic           of;
        logic [SWD-1:0] x;
        logic [SWD-1:0] y;
        logic [SWD-1:0] s;

        pipelined_adder #(.WIDTH(SWD), .STAGES(SST)) u_sw (
            .clk      (clk),
            .rst_n    (r_n),
            .in_valid (iv),
            .in_ready (ir),
            .a        (x),
            .b        (y),
            .op       (sop),
            .cin      (ci),
            .out_valid(ov),
            .out_ready(1'b1),
            .sum      (s),
            .cout     (co),
            .ovf      (of)
        );

        initial begin
            logic [SWD:0]   full;
            logic [SWD-1:0] bb;
            int             n;
            r_n = 1'b0; iv = 1'b0; x = '0; y = '0; sop = 1'b0; ci = 1'b0;
            repeat (3) @(posedge clk);
            #1 r_n = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                x   = SWD'($urandom);
                y   = SWD'($urandom);
                sop = i[0];
                ci  = 1'($urandom_range(0, 1));
                bb  = sop ? ~y : y;
                full = {1'b0, x} + {1'b0, bb} + (SWD + 1)'(sop ? 1'b1 : ci);
                chk($sformatf("sweep%0d_in_ready", g), ir, 1);
                iv = 1'b1;
                @(posedge clk);
                #1 iv = 1'b0;
                n = 1;
                @(negedge clk);
                while (!ov && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk($sformatf("sweep%0d_latency", g), n, SST);
                chk($sformatf("sweep%0d_sum", g), s, full[SWD-1:0]);
                chk($sformatf("sweep%0d_cout", g), co, full[SWD]);
                chk($sformatf("sweep%0d_ovf", g), of,
                    (x[SWD-1] == bb[SWD-1]) && (full[SWD-1] != x[SWD-1]));
            end
            sw_done++;
        end
    end

endmodule
